code_judge: RTL and testbench

- Responder side of the game controller handshake.
- Consumes the controller's showing/start/startInput/random and answers with endOfShow, infail, insuccess and repeatRst.
- Runs the 5 s code display and the 20 s countdown, and verifies the player's entered code against the latched random code.
- Drives the digit/status display data for the code and the remaining time.

---
 rtl/code_judge.sv | 201 ++++++++++++++++++++
 tb/tb_code_judge.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/code_judge.sv
// code_judge: responder side of the game controller handshake.
// Shows the controller's random code for SHOW_SEC seconds. It then gives the
// player LIMIT_SEC seconds and MAX_TRIES confirms to re-enter that code, and
// holds the result for RESULT_SEC seconds before asking the controller to
// restart.
// Ports:
//   clk, rst_p              clock, synchronous active-high reset
//   showing                 controller requests display; low aborts the round
//   start, startInput       both high enable the entry countdown and confirms
//   random[4:0]             code offered by the controller
//   code_in[4:0]            player switches
//   btn_confirm             confirm button level (rising edge used)
//   endOfShow               display phase over (level)
//   infail, insuccess       round result (level)
//   repeatRst               one-cycle restart request
//   code_disp[4:0]          code shown during SHOW, else 0
//   sec_left[4:0]           seconds remaining in the current timed state
//   tries_left[2:0]         confirms remaining
module code_judge #(
  parameter int unsigned TICK_DIV   = 50000000,
  parameter int unsigned SHOW_SEC   = 5,
  parameter int unsigned LIMIT_SEC  = 20,
  parameter int unsigned RESULT_SEC = 3,
  parameter int unsigned MAX_TRIES  = 3
) (
  input  logic       clk,
  input  logic       rst_p,
  input  logic       showing,
  input  logic       start,
  input  logic       startInput,
  input  logic [4:0] random,
  input  logic [4:0] code_in,
  input  logic       btn_confirm,
  output logic       endOfShow,
  output logic       infail,
  output logic       insuccess,
  output logic       repeatRst,
  output logic [4:0] code_disp,
  output logic [4:0] sec_left,
  output logic [2:0] tries_left
);

  localparam int unsigned CODE_W = 5;
  localparam int unsigned SEC_W  = 5;
  localparam int unsigned TRY_W  = 3;
  localparam int unsigned CNT_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_SHOW, S_INPUT, S_SUCCESS, S_FAIL, S_RESTART
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                btn_q;
  logic [CODE_W-1:0]   code_q, code_d;
  logic                end_q, end_d;
  logic                infail_q, infail_d;
  logic                insucc_q, insucc_d;
  logic                rep_q, rep_d;
  logic [CODE_W-1:0]   disp_q, disp_d;
  logic [SEC_W-1:0]    sec_q, sec_d;
  logic [TRY_W-1:0]    tries_q, tries_d;

  logic cnt_run, tick, input_active, confirm_edge, good_try, bad_try, last_sec;

  // Qualifiers: tick, button edge and confirm evaluation for this cycle.
  always_comb begin
    input_active = start & startInput;
    case (state_q)
      S_SHOW, S_SUCCESS, S_FAIL: cnt_run = 1'b1;
      S_INPUT:                   cnt_run = input_active;
      default:                   cnt_run = 1'b0;
    endcase
    tick         = cnt_run && (cnt_q == CNT_W'(TICK_DIV - 1));
    confirm_edge = btn_confirm & ~btn_q;
    good_try     = (state_q == S_INPUT) && input_active && confirm_edge && (code_in == code_q);
    bad_try      = (state_q == S_INPUT) && input_active && confirm_edge && (code_in != code_q);
    last_sec     = tick && (sec_q == SEC_W'(1));
  end

  // State register and all datapath flops.
  always_ff @(posedge clk) begin
    if (rst_p) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      btn_q    <= 1'b0;
      code_q   <= '0;
      end_q    <= 1'b0;
      infail_q <= 1'b0;
      insucc_q <= 1'b0;
      rep_q    <= 1'b0;
      disp_q   <= '0;
      sec_q    <= '0;
      tries_q  <= TRY_W'(MAX_TRIES);
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      btn_q    <= btn_confirm;
      code_q   <= code_d;
      end_q    <= end_d;
      infail_q <= infail_d;
      insucc_q <= insucc_d;
      rep_q    <= rep_d;
      disp_q   <= disp_d;
      sec_q    <= sec_d;
      tries_q  <= tries_d;
    end
  end

  // Next-state logic; dropping showing aborts any active phase.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (showing) state_d = S_SHOW;
      S_SHOW: begin
        if (!showing)      state_d = S_IDLE;
        else if (last_sec) state_d = S_INPUT;
      end
      S_INPUT: begin
        // Correct confirm beats a simultaneous final tick.
        if (!showing)                                   state_d = S_IDLE;
        else if (good_try)                              state_d = S_SUCCESS;
        else if (bad_try && (tries_q <= TRY_W'(1)))     state_d = S_FAIL;
        else if (last_sec)                              state_d = S_FAIL;
      end
      S_SUCCESS, S_FAIL: begin
        if (!showing)      state_d = S_IDLE;
        else if (last_sec) state_d = S_RESTART;
      end
      S_RESTART: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Tick counter restarts on every state change and after each tick.
  always_comb begin
    if ((state_d != state_q) || !cnt_run || tick) cnt_d = '0;
    else                                          cnt_d = cnt_q + CNT_W'(1);
  end

  // Registered output values for the state being entered or held.
  always_comb begin
    code_d   = code_q;
    end_d    = end_q;
    infail_d = infail_q;
    insucc_d = insucc_q;
    rep_d    = 1'b0;
    disp_d   = disp_q;
    sec_d    = sec_q;
    tries_d  = tries_q;
    if (bad_try && (tries_q != '0)) tries_d = tries_q - TRY_W'(1);
    case (state_d)
      S_SHOW: begin
        code_d = random;
        disp_d = random;
        end_d  = 1'b0;
        if (state_q != S_SHOW)        sec_d = SEC_W'(SHOW_SEC);
        else if (tick && sec_q != '0) sec_d = sec_q - SEC_W'(1);
      end
      S_INPUT: begin
        end_d  = 1'b1;
        disp_d = '0;
        if (state_q != S_INPUT)       sec_d = SEC_W'(LIMIT_SEC);
        else if (tick && sec_q != '0) sec_d = sec_q - SEC_W'(1);
      end
      S_SUCCESS, S_FAIL: begin
        disp_d = '0;
        if (state_d == S_SUCCESS) insucc_d = 1'b1;
        else                      infail_d = 1'b1;
        if (state_q != state_d)       sec_d = SEC_W'(RESULT_SEC);
        else if (tick && sec_q != '0) sec_d = sec_q - SEC_W'(1);
      end
      S_RESTART: begin
        rep_d    = 1'b1;
        end_d    = 1'b0;
        infail_d = 1'b0;
        insucc_d = 1'b0;
        disp_d   = '0;
        sec_d    = '0;
        tries_d  = '0;
      end
      default: begin
        end_d    = 1'b0;
        infail_d = 1'b0;
        insucc_d = 1'b0;
        disp_d   = '0;
        sec_d    = '0;
        tries_d  = TRY_W'(MAX_TRIES);
      end
    endcase
  end

  assign endOfShow  = end_q;
  assign infail     = infail_q;
  assign insuccess  = insucc_q;
  assign repeatRst  = rep_q;
  assign code_disp  = disp_q;
  assign sec_left   = sec_q;
  assign tries_left = tries_q;

endmodule

// File: tb/tb_code_judge.sv
// Table-driven bench for code_judge with TICK_DIV=4.
module tb_code_judge;

  logic       clk = 1'b0;
  logic       rst_p;
  logic       showing, start, startInput, btn_confirm;
  logic [4:0] random, code_in;
  logic       endOfShow, infail, insuccess, repeatRst;
  logic [4:0] code_disp, sec_left;
  logic [2:0] tries_left;

  int n_checks = 0;
  int n_errors = 0;

  code_judge #(
    .TICK_DIV(4), .SHOW_SEC(5), .LIMIT_SEC(20), .RESULT_SEC(3), .MAX_TRIES(3)
  ) dut (
    .clk(clk), .rst_p(rst_p), .showing(showing), .start(start),
    .startInput(startInput), .random(random), .code_in(code_in),
    .btn_confirm(btn_confirm), .endOfShow(endOfShow), .infail(infail),
    .insuccess(insuccess), .repeatRst(repeatRst), .code_disp(code_disp),
    .sec_left(sec_left), .tries_left(tries_left)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, sh, st, si, btn;
    logic [4:0] rnd, cin;
    int         cycles;
    logic [6:0] mask;   // end, infail, insucc, rep, disp, sec, tries
    logic       e_end, e_if, e_is, e_rep;
    logic [4:0] e_disp, e_sec;
    logic [2:0] e_tr;
  } vec_t;

  localparam logic [6:0] M_ALL = 7'h7f;
  localparam logic [6:0] M_NE  = 7'h3f;  // endOfShow not compared
  localparam logic [6:0] M_NT  = 7'h7e;  // tries_left not compared
  localparam logic [6:0] M_NES = 7'h3d;  // endOfShow and sec_left not compared

  vec_t vecs[$];

  function automatic vec_t mk(input int rst, input int sh, input int st, input int si,
                              input int btn, input int rnd, input int cin, input int cyc,
                              input logic [6:0] m, input int e_end, input int e_if,
                              input int e_is, input int e_rep, input int e_disp,
                              input int e_sec, input int e_tr);
    vec_t v;
    v.rst = 1'(rst); v.sh = 1'(sh); v.st = 1'(st); v.si = 1'(si); v.btn = 1'(btn);
    v.rnd = 5'(rnd); v.cin = 5'(cin); v.cycles = cyc; v.mask = m;
    v.e_end = 1'(e_end); v.e_if = 1'(e_if); v.e_is = 1'(e_is); v.e_rep = 1'(e_rep);
    v.e_disp = 5'(e_disp); v.e_sec = 5'(e_sec); v.e_tr = 3'(e_tr);
    return v;
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  localparam int R = 5'h16;
  localparam int W = 5'h01;

  initial begin
    int cnt;
    rst_p = 1'b1; showing = 1'b0; start = 1'b0; startInput = 1'b0;
    btn_confirm = 1'b0; random = '0; code_in = '0;
    step(3);
    chk("rst.end", int'(endOfShow), 0);
    chk("rst.infail", int'(infail), 0);
    chk("rst.insucc", int'(insuccess), 0);
    chk("rst.rep", int'(repeatRst), 0);
    chk("rst.disp", int'(code_disp), 0);
    chk("rst.sec", int'(sec_left), 0);
    chk("rst.tries", int'(tries_left), 3);

    // A: show phase countdown, then correct code and restart handshake
    vecs.push_back(mk(0,1,0,0,0,R,0, 1, M_ALL, 0,0,0,0,R, 5,3));
    vecs.push_back(mk(0,1,0,0,0,R,0, 3, M_ALL, 0,0,0,0,R, 5,3));
    vecs.push_back(mk(0,1,0,0,0,R,0, 1, M_ALL, 0,0,0,0,R, 4,3));
    vecs.push_back(mk(0,1,0,0,0,R,0, 4, M_ALL, 0,0,0,0,R, 3,3));
    vecs.push_back(mk(0,1,0,0,0,R,0, 8, M_ALL, 0,0,0,0,R, 1,3));
    vecs.push_back(mk(0,1,0,0,0,R,0, 3, M_ALL, 0,0,0,0,R, 1,3));
    vecs.push_back(mk(0,1,0,0,0,R,0, 1, M_ALL, 1,0,0,0,0,20,3));
    vecs.push_back(mk(0,1,1,1,0,R,R, 2, M_ALL, 1,0,0,0,0,20,3));
    vecs.push_back(mk(0,1,1,1,1,R,R, 1, M_NE,  0,0,1,0,0, 3,3));
    vecs.push_back(mk(0,1,1,1,0,R,R,11, M_NE,  0,0,1,0,0, 1,3));
    vecs.push_back(mk(0,1,1,1,0,R,R, 1, M_NT,  0,0,0,1,0, 0,0));
    vecs.push_back(mk(0,0,0,0,0,R,R, 1, M_ALL, 0,0,0,0,0, 0,3));
    // B: three wrong confirms (one held press), then reset mid-FAIL
    vecs.push_back(mk(0,1,0,0,0,R,W, 1, M_ALL, 0,0,0,0,R, 5,3));
    vecs.push_back(mk(0,1,0,0,0,R,W,20, M_ALL, 1,0,0,0,0,20,3));
    vecs.push_back(mk(0,1,1,1,1,R,W, 1, M_ALL, 1,0,0,0,0,20,2));
    vecs.push_back(mk(0,1,1,1,1,R,W, 2, M_ALL, 1,0,0,0,0,20,2));
    vecs.push_back(mk(0,1,1,1,0,R,W, 1, M_ALL, 1,0,0,0,0,19,2));
    vecs.push_back(mk(0,1,1,1,1,R,W, 1, M_ALL, 1,0,0,0,0,19,1));
    vecs.push_back(mk(0,1,1,1,0,R,W, 1, M_ALL, 1,0,0,0,0,19,1));
    vecs.push_back(mk(0,1,1,1,1,R,W, 1, M_NE,  0,1,0,0,0, 3,0));
    vecs.push_back(mk(0,1,1,1,0,R,W, 2, M_NE,  0,1,0,0,0, 3,0));
    vecs.push_back(mk(1,1,1,1,0,R,W, 1, M_ALL, 0,0,0,0,0, 0,3));
    vecs.push_back(mk(0,0,0,0,0,R,W, 1, M_ALL, 0,0,0,0,0, 0,3));
    // C: timeout with a 10-cycle pause aligned to a second boundary
    vecs.push_back(mk(0,1,1,1,0,R,0, 1, M_ALL, 0,0,0,0,R, 5,3));
    vecs.push_back(mk(0,1,1,1,0,R,0,20, M_ALL, 1,0,0,0,0,20,3));
    vecs.push_back(mk(0,1,1,1,0,R,0,40, M_ALL, 1,0,0,0,0,10,3));
    vecs.push_back(mk(0,1,1,0,0,R,0,10, M_ALL, 1,0,0,0,0,10,3));
    vecs.push_back(mk(0,1,1,1,0,R,0,39, M_ALL, 1,0,0,0,0, 1,3));
    vecs.push_back(mk(0,1,1,1,0,R,0, 1, M_NES, 0,1,0,0,0, 0,3));
    vecs.push_back(mk(0,0,1,1,0,R,0, 1, M_ALL, 0,0,0,0,0, 0,3));
    // D: correct confirm on the final tick
    vecs.push_back(mk(0,1,1,1,0,R,R, 1, M_ALL, 0,0,0,0,R, 5,3));
    vecs.push_back(mk(0,1,1,1,0,R,R,20, M_ALL, 1,0,0,0,0,20,3));
    vecs.push_back(mk(0,1,1,1,0,R,R,79, M_ALL, 1,0,0,0,0, 1,3));
    vecs.push_back(mk(0,1,1,1,1,R,R, 1, M_NE,  0,0,1,0,0, 3,3));
    vecs.push_back(mk(0,0,1,1,0,R,R, 1, M_ALL, 0,0,0,0,0, 0,3));

    for (int i = 0; i < vecs.size(); i++) begin
      rst_p = vecs[i].rst; showing = vecs[i].sh; start = vecs[i].st;
      startInput = vecs[i].si; btn_confirm = vecs[i].btn;
      random = vecs[i].rnd; code_in = vecs[i].cin;
      step(vecs[i].cycles);
      if (vecs[i].mask[6]) chk($sformatf("v%0d.end", i), int'(endOfShow), int'(vecs[i].e_end));
      if (vecs[i].mask[5]) chk($sformatf("v%0d.infail", i), int'(infail), int'(vecs[i].e_if));
      if (vecs[i].mask[4]) chk($sformatf("v%0d.insucc", i), int'(insuccess), int'(vecs[i].e_is));
      if (vecs[i].mask[3]) chk($sformatf("v%0d.rep", i), int'(repeatRst), int'(vecs[i].e_rep));
      if (vecs[i].mask[2]) chk($sformatf("v%0d.disp", i), int'(code_disp), int'(vecs[i].e_disp));
      if (vecs[i].mask[1]) chk($sformatf("v%0d.sec", i), int'(sec_left), int'(vecs[i].e_sec));
      if (vecs[i].mask[0]) chk($sformatf("v%0d.tries", i), int'(tries_left), int'(vecs[i].e_tr));
    end

    // E: endOfShow latency with a bounded wait, then abort mid-INPUT
    rst_p = 1'b0; showing = 1'b1; start = 1'b0; startInput = 1'b0;
    btn_confirm = 1'b0; random = 5'h09; code_in = '0;
    cnt = 0;
    while (!endOfShow && cnt < 40) begin
      step(1);
      cnt++;
      if (cnt == 10) chk("e.disp_show", int'(code_disp), 9);
    end
    chk("e.eos_latency", cnt, 21);
    chk("e.disp_input", int'(code_disp), 0);
    step(3);
    showing = 1'b0;
    step(1);
    chk("e.abort_end", int'(endOfShow), 0);
    chk("e.abort_sec", int'(sec_left), 0);
    chk("e.abort_tries", int'(tries_left), 3);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("e.no_rep%0d", k), int'(repeatRst), 0);
      step(1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
